// File: rtl/collision_resolver.sv
// rtl/collision_resolver.sv - equal-mass elastic collision resolver for one particle pair
//
// Purpose: on a collision flag, captures one particle pair, swaps the two
// velocity vectors, then steps the balls apart one pixel per cycle until they
// no longer overlap (or MAX_SEP steps have been taken), and presents the
// resolved positions/velocities with a one-cycle done pulse.
//
// Ports:
//   clock, resetn                 clock and synchronous active-low reset
//   start                         collision flag, sampled only while idle
//   ball{1,2}{x,y}_in             pair positions (x 9 bits, y 8 bits)
//   v{1,2}{x,y}_in                signed VW-bit velocity components
//   ball{1,2}{x,y}_out            resolved positions, held until next done
//   v{1,2}{x,y}_out               resolved (swapped) velocities
//   busy                          high whenever the block is not idle
//   done                          one-cycle pulse, outputs valid while high
//   sep_fail                      pair still overlapped after MAX_SEP steps
//   coll_count                    16-bit successful-resolution counter,
//                                 present only with COLLISION_COUNT_EN

module collision_resolver #(
    parameter int BALL_WIDTH = 19,
    parameter int VW         = 4,
    parameter int X_MAX      = 319,
    parameter int Y_MAX      = 239,
    parameter int MAX_SEP    = 31
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic [8:0]    ball1x_in,
    input  logic [7:0]    ball1y_in,
    input  logic [8:0]    ball2x_in,
    input  logic [7:0]    ball2y_in,
    input  logic [VW-1:0] v1x_in,
    input  logic [VW-1:0] v1y_in,
    input  logic [VW-1:0] v2x_in,
    input  logic [VW-1:0] v2y_in,
    output logic [8:0]    ball1x_out,
    output logic [7:0]    ball1y_out,
    output logic [8:0]    ball2x_out,
    output logic [7:0]    ball2y_out,
    output logic [VW-1:0] v1x_out,
    output logic [VW-1:0] v1y_out,
    output logic [VW-1:0] v2x_out,
    output logic [VW-1:0] v2y_out,
    output logic          busy,
    output logic          done,
    output logic          sep_fail
`ifdef COLLISION_COUNT_EN
    ,
    output logic [15:0]   coll_count
`endif
);

    localparam int              CW        = (MAX_SEP < 1) ? 1 : $clog2(MAX_SEP + 1);
    localparam logic [9:0]      BW_X      = 10'(BALL_WIDTH);
    localparam logic [8:0]      BW_Y      = 9'(BALL_WIDTH);
    localparam logic [8:0]      XM        = 9'(X_MAX);
    localparam logic [7:0]      YM        = 8'(Y_MAX);
    localparam logic [CW-1:0]   SEP_LIMIT = CW'(MAX_SEP);

    typedef enum logic [1:0] {IDLE, SWAP, SEPARATE, DONE} state_t;

    state_t state, state_n;

    logic [8:0]    b1x, b2x;
    logic [7:0]    b1y, b2y;
    logic [VW-1:0] w1x, w1y, w2x, w2y;
    logic [CW-1:0] step_cnt;
    logic          fail_r;

    logic [9:0] dx, adx;
    logic [8:0] dy, ady;
    logic       overlap, at_limit, use_x, d_pos;
    logic [8:0] b1x_n, b2x_n;
    logic [7:0] b1y_n, b2y_n;

    // Pair geometry from the working registers. The extra top bit makes the
    // unsigned coordinate difference a proper two's-complement value.
    always_comb begin
        dx       = {1'b0, b1x} - {1'b0, b2x};
        dy       = {1'b0, b1y} - {1'b0, b2y};
        adx      = dx[9] ? (~dx + 10'd1) : dx;
        ady      = dy[8] ? (~dy + 9'd1) : dy;
        overlap  = (adx <= BW_X) && (ady <= BW_Y);
        at_limit = (step_cnt == SEP_LIMIT);
        use_x    = (adx >= {1'b0, ady});
        // d_pos: ball 1 lies strictly above ball 2 on the chosen axis, so it
        // moves up. A zero difference falls through to "ball 1 moves down".
        d_pos    = use_x ? (!dx[9] && (dx != 10'd0)) : (!dy[8] && (dy != 9'd0));
    end

    // One separation step; each ball clamps at its own wall independently.
    always_comb begin
        b1x_n = b1x;
        b2x_n = b2x;
        b1y_n = b1y;
        b2y_n = b2y;
        if (use_x) begin
            if (d_pos) begin
                if (b1x != XM)   b1x_n = b1x + 9'd1;
                if (b2x != 9'd0) b2x_n = b2x - 9'd1;
            end else begin
                if (b1x != 9'd0) b1x_n = b1x - 9'd1;
                if (b2x != XM)   b2x_n = b2x + 9'd1;
            end
        end else begin
            if (d_pos) begin
                if (b1y != YM)   b1y_n = b1y + 8'd1;
                if (b2y != 8'd0) b2y_n = b2y - 8'd1;
            end else begin
                if (b1y != 8'd0) b1y_n = b1y - 8'd1;
                if (b2y != YM)   b2y_n = b2y + 8'd1;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (start) state_n = SWAP;
            SWAP:     state_n = SEPARATE;
            SEPARATE: if (!overlap || at_limit) state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            b1x        <= '0;
            b1y        <= '0;
            b2x        <= '0;
            b2y        <= '0;
            w1x        <= '0;
            w1y        <= '0;
            w2x        <= '0;
            w2y        <= '0;
            step_cnt   <= '0;
            fail_r     <= 1'b0;
            ball1x_out <= '0;
            ball1y_out <= '0;
            ball2x_out <= '0;
            ball2y_out <= '0;
            v1x_out    <= '0;
            v1y_out    <= '0;
            v2x_out    <= '0;
            v2y_out    <= '0;
            done       <= 1'b0;
            sep_fail   <= 1'b0;
`ifdef COLLISION_COUNT_EN
            coll_count <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        b1x <= ball1x_in;
                        b1y <= ball1y_in;
                        b2x <= ball2x_in;
                        b2y <= ball2y_in;
                        w1x <= v1x_in;
                        w1y <= v1y_in;
                        w2x <= v2x_in;
                        w2y <= v2y_in;
                    end
                end
                SWAP: begin
                    w1x      <= w2x;
                    w1y      <= w2y;
                    w2x      <= w1x;
                    w2y      <= w1y;
                    step_cnt <= '0;
                end
                SEPARATE: begin
                    if (!overlap || at_limit) begin
                        fail_r <= overlap;
                    end else begin
                        b1x      <= b1x_n;
                        b1y      <= b1y_n;
                        b2x      <= b2x_n;
                        b2y      <= b2y_n;
                        step_cnt <= step_cnt + CW'(1);
                    end
                end
                DONE: begin
                    ball1x_out <= b1x;
                    ball1y_out <= b1y;
                    ball2x_out <= b2x;
                    ball2y_out <= b2y;
                    v1x_out    <= w1x;
                    v1y_out    <= w1y;
                    v2x_out    <= w2x;
                    v2y_out    <= w2y;
                    sep_fail   <= fail_r;
                    done       <= 1'b1;
`ifdef COLLISION_COUNT_EN
                    if (!fail_r) coll_count <= coll_count + 16'd1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_resolver.sv
// tb/tb_collision_resolver.sv - randomized model-checked bench for collision_resolver

module tb_collision_resolver;

    localparam int XMAX = 319;
    localparam int YMAX = 239;
    localparam int BW   = 19;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn, start;
    logic [8:0] b1x_i, b2x_i;
    logic [7:0] b1y_i, b2y_i;
    logic [3:0] v1x_i, v1y_i, v2x_i, v2y_i;

    logic [8:0]  o1x [2];
    logic [7:0]  o1y [2];
    logic [8:0]  o2x [2];
    logic [7:0]  o2y [2];
    logic [3:0]  ov1x [2];
    logic [3:0]  ov1y [2];
    logic [3:0]  ov2x [2];
    logic [3:0]  ov2y [2];
    logic        bz [2];
    logic        dn [2];
    logic        sf [2];
    logic [15:0] cc [2];

    collision_resolver #(.MAX_SEP(31)) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .ball1x_in(b1x_i), .ball1y_in(b1y_i), .ball2x_in(b2x_i), .ball2y_in(b2y_i),
        .v1x_in(v1x_i), .v1y_in(v1y_i), .v2x_in(v2x_i), .v2y_in(v2y_i),
        .ball1x_out(o1x[0]), .ball1y_out(o1y[0]), .ball2x_out(o2x[0]), .ball2y_out(o2y[0]),
        .v1x_out(ov1x[0]), .v1y_out(ov1y[0]), .v2x_out(ov2x[0]), .v2y_out(ov2y[0]),
        .busy(bz[0]), .done(dn[0]), .sep_fail(sf[0])
`ifdef COLLISION_COUNT_EN
        , .coll_count(cc[0])
`endif
    );

    collision_resolver #(.MAX_SEP(5)) dut5 (
        .clock(clock), .resetn(resetn), .start(start),
        .ball1x_in(b1x_i), .ball1y_in(b1y_i), .ball2x_in(b2x_i), .ball2y_in(b2y_i),
        .v1x_in(v1x_i), .v1y_in(v1y_i), .v2x_in(v2x_i), .v2y_in(v2y_i),
        .ball1x_out(o1x[1]), .ball1y_out(o1y[1]), .ball2x_out(o2x[1]), .ball2y_out(o2y[1]),
        .v1x_out(ov1x[1]), .v1y_out(ov1y[1]), .v2x_out(ov2x[1]), .v2y_out(ov2y[1]),
        .busy(bz[1]), .done(dn[1]), .sep_fail(sf[1])
`ifdef COLLISION_COUNT_EN
        , .coll_count(cc[1])
`endif
    );

`ifndef COLLISION_COUNT_EN
    assign cc[0] = '0;
    assign cc[1] = '0;
`endif

    typedef struct packed {
        int b1x; int b1y; int b2x; int b2y;
        logic [3:0] v1x; logic [3:0] v1y; logic [3:0] v2x; logic [3:0] v2y;
    } in_t;

    typedef struct packed {
        int b1x; int b1y; int b2x; int b2y;
        logic [3:0] v1x; logic [3:0] v1y; logic [3:0] v2x; logic [3:0] v2y;
        bit fail; int lat; int done_cyc; int cc;
    } exp_t;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    bit   armed = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    int   blo [2];
    int   bhi [2];
    int   cnt_exp [2];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int up(input int v, input int lim);
        return (v >= lim) ? v : v + 1;
    endfunction

    function automatic int dn1(input int v);
        return (v <= 0) ? v : v - 1;
    endfunction

    // Direct statement of the resolution rules on plain integers.
    function automatic exp_t model(input in_t t, input int max_sep);
        exp_t r;
        int x1, y1, x2, y2, steps, dx, dy;
        bit fin;
        x1 = t.b1x; y1 = t.b1y; x2 = t.b2x; y2 = t.b2y;
        steps = 0; fin = 1'b0;
        r = '0;
        while (!fin) begin
            dx = x1 - x2;
            dy = y1 - y2;
            if (iabs(dx) > BW || iabs(dy) > BW) begin
                fin = 1'b1;
            end else if (steps == max_sep) begin
                r.fail = 1'b1;
                fin = 1'b1;
            end else begin
                if (iabs(dx) >= iabs(dy)) begin
                    if (dx > 0) begin x1 = up(x1, XMAX); x2 = dn1(x2); end
                    else        begin x1 = dn1(x1); x2 = up(x2, XMAX); end
                end else begin
                    if (dy > 0) begin y1 = up(y1, YMAX); y2 = dn1(y2); end
                    else        begin y1 = dn1(y1); y2 = up(y2, YMAX); end
                end
                steps++;
            end
        end
        r.b1x = x1; r.b1y = y1; r.b2x = x2; r.b2y = y2;
        r.v1x = t.v2x; r.v1y = t.v2y; r.v2x = t.v1x; r.v2y = t.v1y;
        r.lat = 3 + steps;
        return r;
    endfunction

    task automatic cmp(input int d, input logic dv, input logic bv, input logic sv,
                       input logic [8:0] x1, input logic [7:0] y1,
                       input logic [8:0] x2, input logic [7:0] y2,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] e,
                       input logic [15:0] ccv);
        exp_t  ex;
        bit    have;
        string p;
        p = (d == 0) ? "d31" : "d5";
        chk({p, "_busy"}, int'(bv), int'(cyc >= blo[d] && cyc <= bhi[d]));
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        ex = '0;
        if (have) ex = (d == 0) ? q0[0] : q1[0];
        if (dv) begin
            if (!have) begin
                chk({p, "_spurious_done"}, 1, 0);
            end else begin
                chk({p, "_done_cycle"}, cyc, ex.done_cyc);
                chk({p, "_b1x"}, int'(x1), ex.b1x);
                chk({p, "_b1y"}, int'(y1), ex.b1y);
                chk({p, "_b2x"}, int'(x2), ex.b2x);
                chk({p, "_b2y"}, int'(y2), ex.b2y);
                chk({p, "_v1x"}, int'(a), int'(ex.v1x));
                chk({p, "_v1y"}, int'(b), int'(ex.v1y));
                chk({p, "_v2x"}, int'(c), int'(ex.v2x));
                chk({p, "_v2y"}, int'(e), int'(ex.v2y));
                chk({p, "_sep_fail"}, int'(sv), int'(ex.fail));
`ifdef COLLISION_COUNT_EN
                chk({p, "_coll_count"}, int'(ccv), ex.cc);
`endif
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end else if (have && cyc > ex.done_cyc) begin
            chk({p, "_done_missing"}, 0, 1);
            if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
    endtask

    always begin
        @(posedge clock);
        #2;
        if (armed) begin
            for (int d = 0; d < 2; d++)
                cmp(d, dn[d], bz[d], sf[d], o1x[d], o1y[d], o2x[d], o2y[d],
                    ov1x[d], ov1y[d], ov2x[d], ov2y[d], cc[d]);
        end
    end

    task automatic scramble();
        b1x_i = 9'($urandom_range(0, 511)); b2x_i = 9'($urandom_range(0, 511));
        b1y_i = 8'($urandom_range(0, 255)); b2y_i = 8'($urandom_range(0, 255));
        v1x_i = 4'($urandom); v1y_i = 4'($urandom);
        v2x_i = 4'($urandom); v2y_i = 4'($urandom);
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            blo[d] = 1; bhi[d] = 0; cnt_exp[d] = 0;
        end
    endtask

    task automatic issue(input in_t t, input bit mid, input bit wait_done,
                         output exp_t r31, output exp_t r5);
        int base;
        @(negedge clock);
        resetn = 1'b1;
        b1x_i = 9'(t.b1x); b1y_i = 8'(t.b1y); b2x_i = 9'(t.b2x); b2y_i = 8'(t.b2y);
        v1x_i = t.v1x; v1y_i = t.v1y; v2x_i = t.v2x; v2y_i = t.v2y;
        start = 1'b1;
        base = cyc;
        r31 = model(t, 31);
        r5  = model(t, 5);
        if (!r31.fail) cnt_exp[0]++;
        if (!r5.fail)  cnt_exp[1]++;
        r31.cc = cnt_exp[0] & 16'hFFFF;
        r5.cc  = cnt_exp[1] & 16'hFFFF;
        r31.done_cyc = base + 1 + r31.lat;
        r5.done_cyc  = base + 1 + r5.lat;
        blo[0] = base + 1; bhi[0] = base + r31.lat;
        blo[1] = base + 1; bhi[1] = base + r5.lat;
        q0.push_back(r31);
        q1.push_back(r5);
        @(negedge clock);
        start = 1'b0;
        scramble();
        if (mid) begin
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        if (wait_done)
            while (cyc < r31.done_cyc || cyc < r5.done_cyc) @(negedge clock);
    endtask

    function automatic in_t mk(input int ax, input int ay, input int bx, input int by,
                               input int p, input int q, input int r, input int s);
        in_t t;
        t.b1x = ax; t.b1y = ay; t.b2x = bx; t.b2y = by;
        t.v1x = 4'(p); t.v1y = 4'(q); t.v2x = 4'(r); t.v2y = 4'(s);
        return t;
    endfunction

    function automatic int clampi(input int v, input int lim);
        return (v < 0) ? 0 : ((v > lim) ? lim : v);
    endfunction

    function automatic in_t rnd_pair();
        in_t t;
        int  sel;
        sel = int'($urandom_range(0, 5));
        t.b1x = (sel == 0) ? 0 : ((sel == 1) ? XMAX : int'($urandom_range(0, XMAX)));
        sel = int'($urandom_range(0, 5));
        t.b1y = (sel == 0) ? 0 : ((sel == 1) ? YMAX : int'($urandom_range(0, YMAX)));
        t.b2x = clampi(t.b1x + int'($urandom_range(0, 50)) - 25, XMAX);
        t.b2y = clampi(t.b1y + int'($urandom_range(0, 50)) - 25, YMAX);
        t.v1x = 4'($urandom); t.v1y = 4'($urandom);
        t.v2x = 4'($urandom); t.v2y = 4'($urandom);
        return t;
    endfunction

    in_t  tx_x, tx_apart, tx_clamp;
    exp_t ra, rb;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_x     = mk(100, 50, 110, 50, 2, 0, -1, 0);
        tx_apart = mk(10, 10, 40, 10, 1, 1, -2, 3);
        tx_clamp = mk(0, 100, 0, 100, 3, -4, 5, 7);
        clear_model();
        resetn = 1'b0;
        start  = 1'b1;
        scramble();
        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("rst_b1x", int'(o1x[d]), 0);
            chk("rst_b2y", int'(o2y[d]), 0);
            chk("rst_v2x", int'(ov2x[d]), 0);
            chk("rst_busy", int'(bz[d]), 0);
            chk("rst_done", int'(dn[d]), 0);
            chk("rst_sep_fail", int'(sf[d]), 0);
        end
        armed = 1'b1;

        // Start held across reset release is taken on the first edge after it.
        issue(tx_x, 1'b0, 1'b1, ra, rb);
        chk("model_x_lat", ra.lat, 8);
        chk("model_x_b1x", ra.b1x, 95);
        chk("model_x_b2x", ra.b2x, 115);
        chk("x_b1x", int'(o1x[0]), 95);
        chk("x_b1y", int'(o1y[0]), 50);
        chk("x_b2x", int'(o2x[0]), 115);
        chk("x_v1x", int'(ov1x[0]), 15);
        chk("x_v2x", int'(ov2x[0]), 2);
        chk("x_sep_fail", int'(sf[0]), 0);

        issue(tx_apart, 1'b1, 1'b1, ra, rb);
        chk("model_apart_lat", ra.lat, 3);
        chk("apart_b1x", int'(o1x[0]), 10);
        chk("apart_b2x", int'(o2x[0]), 40);
        chk("apart_v1x", int'(ov1x[0]), 14);
        chk("apart_v1y", int'(ov1y[0]), 3);
        chk("apart_v2x", int'(ov2x[0]), 1);
        chk("apart_v2y", int'(ov2y[0]), 1);

        issue(tx_clamp, 1'b1, 1'b1, ra, rb);
        chk("model_clamp_lat", ra.lat, 23);
        chk("model_clamp5_fail", int'(rb.fail), 1);
        chk("clamp_b1x", int'(o1x[0]), 0);
        chk("clamp_b2x", int'(o2x[0]), 20);
        chk("clamp_sep_fail", int'(sf[0]), 0);
        chk("clamp5_b1x", int'(o1x[1]), 0);
        chk("clamp5_b2x", int'(o2x[1]), 5);
        chk("clamp5_sep_fail", int'(sf[1]), 1);

        for (int i = 0; i < 40; i++) begin
            issue(rnd_pair(), 1'($urandom_range(0, 1)), 1'b1, ra, rb);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        // Abort during separation: no done, everything cleared.
        issue(tx_clamp, 1'b0, 1'b0, ra, rb);
        repeat (2) @(negedge clock);
        resetn = 1'b0;
        clear_model();
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("abort_busy", int'(bz[d]), 0);
            chk("abort_done", int'(dn[d]), 0);
            chk("abort_b2x", int'(o2x[d]), 0);
            chk("abort_v1x", int'(ov1x[d]), 0);
        end
        resetn = 1'b1;
        repeat (35) @(negedge clock);

        issue(tx_x, 1'b0, 1'b1, ra, rb);
        chk("post_abort_b1x", int'(o1x[0]), 95);
        chk("post_abort_b2x", int'(o2x[0]), 115);
        issue(tx_apart, 1'b0, 1'b1, ra, rb);
        issue(tx_clamp, 1'b0, 1'b1, ra, rb);
`ifdef COLLISION_COUNT_EN
        chk("coll_count_three", int'(cc[0]), 3);
        chk("coll_count_fail_skip", int'(cc[1]), 2);
`endif
        repeat (4) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
